// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: op codes and FSM state encoding shared by the HI/LO multiply/divide unit.
package muldiv_unit_pkg;
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  typedef enum logic [1:0] {IDLE, CALC, FIX} md_state_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, shift-add multiply (mode_i=0) or restoring divide (mode_i=1).
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               mode_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opd_i,
  output logic [2*WIDTH-1:0] acc_o
);
  logic [WIDTH:0] sum, rem, diff;
  logic           ge;
  always_comb begin
    sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opd_i} : '0);
    // shifted partial remainder needs one extra bit before the compare
    rem   = acc_i[2*WIDTH-1:WIDTH-1];
    diff  = rem - {1'b0, opd_i};
    ge    = !diff[WIDTH];
    acc_o = mode_i ? {ge ? diff[WIDTH-1:0] : rem[WIDTH-1:0], acc_i[WIDTH-2:0], ge}
                   : {sum, acc_i[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO, with busy/done handshake.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  md_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step, prod;
  logic [WIDTH-1:0]   opd_q, opd_d, hi_q, hi_d, lo_q, lo_d, abs_a, abs_b, quo, rmd;
  logic               div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, bz_q, bz_d;
  logic               done_q, done_d, div0_q, div0_d, sgn, a_neg, b_neg, is_div;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode_i (div_q),
    .acc_i  (acc_q),
    .opd_i  (opd_q),
    .acc_o  (step)
  );

  always_comb begin
    sgn    = (op == MD_MULT) || (op == MD_DIV);
    is_div = (op == MD_DIV) || (op == MD_DIVU);
    a_neg  = sgn & a[WIDTH-1];
    b_neg  = sgn & b[WIDTH-1];
    abs_a  = a_neg ? -a : a;
    abs_b  = b_neg ? -b : b;
    prod   = neg_q ? -acc_q : acc_q;
    // divide by zero leaves |a| as remainder, so the dividend sign restores hi=a
    quo    = bz_q ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    rmd    = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opd_d   = opd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    bz_d    = bz_q;
    div0_d  = div0_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start && !flush) begin
        hi_d = (op == MD_MTHI) ? a : hi_q;
        lo_d = (op == MD_MTLO) ? a : lo_q;
        if (!op[2]) begin
          state_d = CALC;
          cnt_d   = CNT_W'(WIDTH);
          div_d   = is_div;
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          bz_d    = (b == '0);
          acc_d   = {{WIDTH{1'b0}}, is_div ? abs_a : abs_b};
          opd_d   = is_div ? abs_b : abs_a;
        end
      end
      CALC: begin
        acc_d   = step;
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = flush ? IDLE : (cnt_q == CNT_W'(1)) ? FIX : CALC;
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          done_d = 1'b1;
          hi_d   = div_q ? rmd : prod[2*WIDTH-1:WIDTH];
          lo_d   = div_q ? quo : prod[WIDTH-1:0];
          div0_d = div_q ? bz_q : div0_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opd_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      bz_q    <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opd_q   <= opd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      bz_q    <= bz_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with hand-computed results for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div0;
  logic [31:0] hi, lo;
  int          vectors = 0, errs = 0, n, bc;

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .div0  (div0),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int bcyc);
    cyc  = 0;
    bcyc = 0;
    while (!done && cyc < 100) begin
      if (busy) bcyc++;
      tick();
      cyc++;
    end
  endtask

  initial begin
    tick();
    chk("rst_hilo", {hi, lo}, 64'h0);
    chk("rst_flags", {61'h0, busy, done, div0}, 64'h0);
    reset = 1'b1;
    tick();

    go(MD_MULT, 32'hFFFFFFFD, 32'h00000005);
    wait_done(n, bc);
    chk("mult_latency", 64'(n), 64'd33);
    chk("mult_busy_cycles", 64'(bc), 64'd33);
    chk("mult_done", {63'h0, done}, 64'h1);
    chk("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    tick();
    chk("done_pulse", {63'h0, done}, 64'h0);

    go(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(n, bc);
    chk("multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
    go(MD_DIV, 32'hFFFFFFF9, 32'h00000002);
    wait_done(n, bc);
    chk("div_b2b_latency", 64'(n), 64'd33);
    chk("div_neg_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

    go(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n, bc);
    chk("div_min_hilo", {hi, lo}, 64'h00000000_80000000);
    chk("div_min_div0", {63'h0, div0}, 64'h0);

    go(MD_DIVU, 32'h00000007, 32'h00000000);
    wait_done(n, bc);
    chk("div0_latency", 64'(n), 64'd33);
    chk("div0_hilo", {hi, lo}, 64'h00000007_FFFFFFFF);
    chk("div0_flag", {63'h0, div0}, 64'h1);

    go(MD_MTHI, 32'h12345678, 32'h0);
    chk("mthi_hilo", {hi, lo}, 64'h12345678_FFFFFFFF);
    chk("mthi_flags", {62'h0, busy, done}, 64'h0);

    go(MD_MULT, 32'h2, 32'h3);
    go(MD_MTLO, 32'h0000AAAA, 32'h0);
    chk("ignored_busy", {63'h0, busy}, 64'h1);
    wait_done(n, bc);
    chk("mult_small_hilo", {hi, lo}, 64'h00000000_00000006);
    chk("mult_keeps_div0", {63'h0, div0}, 64'h1);
    tick();

    go(MD_DIVU, 32'd100, 32'd7);
    repeat (8) tick();
    chk("pre_flush_busy", {63'h0, busy}, 64'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_idle", {62'h0, busy, done}, 64'h0);
    chk("flush_hilo", {hi, lo}, 64'h00000000_00000006);
    repeat (40) begin
      if (done) chk("flush_no_done", {63'h0, done}, 64'h0);
      tick();
    end
    chk("flush_hilo_late", {hi, lo}, 64'h00000000_00000006);

    go(MD_DIVU, 32'd100, 32'd7);
    wait_done(n, bc);
    chk("divu_hilo", {hi, lo}, 64'h00000002_0000000E);
    chk("div0_cleared", {63'h0, div0}, 64'h0);
    tick();

    go(MD_DIVU, 32'd100, 32'd7);
    repeat (4) tick();
    reset = 1'b0;
    #1;
    chk("async_rst_hilo", {hi, lo}, 64'h0);
    chk("async_rst_flags", {61'h0, busy, done, div0}, 64'h0);
    tick();
    reset = 1'b1;
    repeat (40) tick();
    chk("post_rst_hilo", {hi, lo}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
